set12_time_controller: RTL and testbench



---
 rtl/set12_pkg.sv | 28 ++
 rtl/set12_time_controller_if.sv | 17 +
 rtl/set12_wrap_counter.sv | 40 ++++
 rtl/set12_time_controller.sv | 111 +++++++++++
 tb/tb_set12_time_controller.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/set12_pkg.sv
// Shared types and constants for the 12-hour time controller.
package set12_pkg;

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_AMPM} state_e;

  localparam int HOUR_LO     = 1;
  localparam int HOUR_HI     = 12;
  localparam int MIN_HI      = 59;
  localparam int RESET_HOURS = 12;

  // Blank-mask digit positions
  localparam int DIG_AMPM   = 0;
  localparam int DIG_SEP    = 1;
  localparam int DIG_HR_LO  = 2;
  localparam int DIG_HR_HI  = 3;
  localparam int DIG_MIN_LO = 4;
  localparam int DIG_MIN_HI = 5;

  function automatic state_e next_state(input state_e s);
    case (s)
      RUN:      return SET_HOUR;
      SET_HOUR: return SET_MIN;
      SET_MIN:  return SET_AMPM;
      default:  return RUN;
    endcase
  endfunction

endpackage

// File: rtl/set12_time_controller_if.sv
// Button/tick inputs and display outputs of the 12-hour controller.
interface set12_time_controller_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       isPM;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic [5:0] digit_blank;
  logic       setting;

  modport master (output tick, btn_mode, btn_up, btn_down,
                  input  isPM, hours, minutes, digit_blank, setting);
  modport slave  (input  tick, btn_mode, btn_up, btn_down,
                  output isPM, hours, minutes, digit_blank, setting);
endinterface

// File: rtl/set12_wrap_counter.sv
// Wrapping LO..HI up/down counter; out-of-range values recover to RST.
module set12_wrap_counter #(
  parameter int LO  = 0,
  parameter int HI  = 59,
  parameter int RST = LO,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         load_i,
  output logic [W-1:0] value_o,
  output logic         wrap_o
);
  localparam logic [W-1:0] LO_V   = W'(LO);
  localparam logic [W-1:0] HI_V   = W'(HI);
  localparam logic [W-1:0] RST_V  = W'(RST);
  localparam logic [W-1:0] SPAN_V = W'(HI - LO);

  logic [W-1:0] val_q, val_d;
  logic         legal;

  // Offset from LO wraps huge when below LO, so one compare covers both ends
  assign legal = (val_q - LO_V) <= SPAN_V;

  always_comb begin
    val_d = val_q;
    if (!legal || load_i)  val_d = RST_V;
    else if (inc_i && !dec_i) val_d = (val_q == HI_V) ? LO_V : val_q + W'(1);
    else if (dec_i && !inc_i) val_d = (val_q == LO_V) ? HI_V : val_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) val_q <= RST_V;
    else       val_q <= val_d;

  assign value_o = val_q;
  assign wrap_o  = legal && inc_i && !dec_i && (val_q == HI_V);
endmodule

// File: rtl/set12_time_controller.sv
// 12-hour clock sequencer: runs from a 1 Hz tick, button-driven set mode with blinking field.
module set12_time_controller
  import set12_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60,
  parameter int CNT_W         = 6
) (
  input logic                     clk,
  input logic                     reset,
  set12_time_controller_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_MIN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;
  logic             ispm_q, ispm_d;
  logic [5:0]       blank_q, blank_d;
  logic             setting_q, setting_d;

  logic       min_inc, min_dec, min_wrap;
  logic       hr_edit_inc, hr_edit_dec, hr_inc;
  logic       ampm_tgl, run_pm_tgl;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic       hr_wrap_unused;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blink_d     = blink_q;
    min_inc     = 1'b0;
    min_dec     = 1'b0;
    hr_edit_inc = 1'b0;
    hr_edit_dec = 1'b0;
    ampm_tgl    = 1'b0;
    if (bus.btn_mode) begin
      state_d = next_state(state_q);
      cnt_d   = '0;
      blink_d = 1'b0;
    end else if (state_q == RUN) begin
      if (bus.tick) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          min_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end else begin
      // Time is frozen while editing; ticks only drive the blink
      cnt_d = '0;
      if (bus.tick) blink_d = ~blink_q;
      case (state_q)
        SET_HOUR: begin hr_edit_inc = bus.btn_up; hr_edit_dec = bus.btn_down; end
        SET_MIN:  begin min_inc = bus.btn_up; min_dec = bus.btn_down; end
        SET_AMPM: ampm_tgl = bus.btn_up ^ bus.btn_down;
        default:  ;
      endcase
    end
  end

  // Minute rollover carries into hours only while running
  assign hr_inc     = (state_q == RUN) ? min_wrap : hr_edit_inc;
  assign run_pm_tgl = (state_q == RUN) && min_wrap && (hours == 4'(HOUR_HI - 1));
  assign ispm_d     = ispm_q ^ (ampm_tgl | run_pm_tgl);

  always_comb begin
    blank_d = '0;
    case (state_d)
      SET_HOUR: blank_d[DIG_HR_HI:DIG_HR_LO]   = {2{blink_d}};
      SET_MIN:  blank_d[DIG_MIN_HI:DIG_MIN_LO] = {2{blink_d}};
      SET_AMPM: blank_d[DIG_AMPM]              = blink_d;
      default:  ;
    endcase
    setting_d = (state_d != RUN);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      blink_q   <= 1'b0;
      ispm_q    <= 1'b0;
      blank_q   <= '0;
      setting_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      blink_q   <= blink_d;
      ispm_q    <= ispm_d;
      blank_q   <= blank_d;
      setting_q <= setting_d;
    end

  set12_wrap_counter #(.LO(0), .HI(MIN_HI), .RST(0), .W(6)) u_min (
    .clk(clk), .reset(reset), .inc_i(min_inc), .dec_i(min_dec), .load_i(1'b0),
    .value_o(minutes), .wrap_o(min_wrap)
  );

  set12_wrap_counter #(.LO(HOUR_LO), .HI(HOUR_HI), .RST(RESET_HOURS), .W(4)) u_hr (
    .clk(clk), .reset(reset), .inc_i(hr_inc), .dec_i(hr_edit_dec), .load_i(1'b0),
    .value_o(hours), .wrap_o(hr_wrap_unused)
  );

  assign bus.isPM        = ispm_q;
  assign bus.hours       = hours;
  assign bus.minutes     = minutes;
  assign bus.digit_blank = blank_q;
  assign bus.setting     = setting_q;
endmodule

// File: tb/tb_set12_time_controller.sv
// Directed bench for set12_time_controller with an expected-output scoreboard queue.
module tb_set12_time_controller;
  logic clk = 1'b0;
  logic reset;
  set12_time_controller_if bus ();

  set12_time_controller #(.TICKS_PER_MIN(2), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pm;
    logic [3:0] h;
    logic [5:0] m;
    logic [5:0] bl;
    logic       st;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic obs_t mk(input logic pm, input int h, input int m,
                              input logic [5:0] bl, input logic st);
    obs_t o;
    o.pm = pm; o.h = 4'(h); o.m = 6'(m); o.bl = bl; o.st = st;
    return o;
  endfunction

  task automatic check_out();
    obs_t  o, e;
    string tg;
    e  = exp_q.pop_front();
    tg = tag_q.pop_front();
    o  = mk(bus.isPM, int'(bus.hours), int'(bus.minutes), bus.digit_blank, bus.setting);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed pm=%0d %0d:%0d blank=%b set=%0d, expected pm=%0d %0d:%0d blank=%b set=%0d",
             tg, o.pm, o.h, o.m, o.bl, o.st, e.pm, e.h, e.m, e.bl, e.st);
    end
  endtask

  // Drive one cycle of pulses at a negedge, check registered outputs at the next negedge
  task automatic step(input logic t, input logic md, input logic u, input logic d,
                      input obs_t e, input string tag);
    bus.tick = t; bus.btn_mode = md; bus.btn_up = u; bus.btn_down = d;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    bus.tick = 1'b0; bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    check_out();
  endtask

  initial begin
    reset = 1'b1;
    bus.tick = 1'b0; bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(mk(0, 12, 0, 6'b0, 0)); tag_q.push_back("reset");
    check_out();
    reset = 1'b0;

    // 1: run with 2 ticks per minute
    step(1,0,0,0, mk(0,12,0,6'b0,0), "t1_tick1");
    step(1,0,0,0, mk(0,12,1,6'b0,0), "t1_tick2");
    step(1,0,0,0, mk(0,12,1,6'b0,0), "t1_tick3");
    step(1,0,0,0, mk(0,12,2,6'b0,0), "t1_tick4");
    step(0,0,0,0, mk(0,12,2,6'b0,0), "t1_idle");

    // 2: 11:59 AM -> 12:00 PM
    step(0,1,0,0, mk(0,12,2,6'b0,1), "t2_mode_hour");
    step(0,0,0,1, mk(0,11,2,6'b0,1), "t2_hr_dn");
    step(0,1,0,0, mk(0,11,2,6'b0,1), "t2_mode_min");
    step(0,0,0,1, mk(0,11,1,6'b0,1), "t2_min_dn1");
    step(0,0,0,1, mk(0,11,0,6'b0,1), "t2_min_dn2");
    step(0,0,0,1, mk(0,11,59,6'b0,1), "t2_min_dn3");
    step(0,1,0,0, mk(0,11,59,6'b0,1), "t2_mode_ampm");
    step(0,1,0,0, mk(0,11,59,6'b0,0), "t2_mode_run");
    step(1,0,0,0, mk(0,11,59,6'b0,0), "t2_tick1");
    step(1,0,0,0, mk(1,12,0,6'b0,0), "t2_am_to_pm");
    // 11:59 PM -> 12:00 AM
    step(0,1,0,0, mk(1,12,0,6'b0,1), "t2b_mode_hour");
    step(0,0,0,1, mk(1,11,0,6'b0,1), "t2b_hr_dn");
    step(0,1,0,0, mk(1,11,0,6'b0,1), "t2b_mode_min");
    step(0,0,0,1, mk(1,11,59,6'b0,1), "t2b_min_dn");
    step(0,1,0,0, mk(1,11,59,6'b0,1), "t2b_mode_ampm");
    step(0,1,0,0, mk(1,11,59,6'b0,0), "t2b_mode_run");
    step(1,0,0,0, mk(1,11,59,6'b0,0), "t2b_tick1");
    step(1,0,0,0, mk(0,12,0,6'b0,0), "t2b_pm_to_am");
    // 12:59 -> 1:00, isPM unchanged
    step(0,1,0,0, mk(0,12,0,6'b0,1), "t2c_mode_hour");
    step(0,1,0,0, mk(0,12,0,6'b0,1), "t2c_mode_min");
    step(0,0,0,1, mk(0,12,59,6'b0,1), "t2c_min_dn");
    step(0,1,0,0, mk(0,12,59,6'b0,1), "t2c_mode_ampm");
    step(0,1,0,0, mk(0,12,59,6'b0,0), "t2c_mode_run");
    step(1,0,0,0, mk(0,12,59,6'b0,0), "t2c_tick1");
    step(1,0,0,0, mk(0,1,0,6'b0,0), "t2c_12_to_1");

    // 3: hour and minute wrap in set mode
    step(0,1,0,0, mk(0,1,0,6'b0,1), "t3_mode_hour");
    step(0,0,0,1, mk(0,12,0,6'b0,1), "t3_hr_dn_1_to_12");
    step(0,0,1,0, mk(0,1,0,6'b0,1), "t3_hr_up_12_to_1");
    step(0,0,0,1, mk(0,12,0,6'b0,1), "t3_hr_dn_a");
    step(0,0,0,1, mk(0,11,0,6'b0,1), "t3_hr_dn_b");
    step(0,1,0,0, mk(0,11,0,6'b0,1), "t3_mode_min");
    step(0,0,0,1, mk(0,11,59,6'b0,1), "t3_min_dn_0_to_59");
    step(0,0,1,0, mk(0,11,0,6'b0,1), "t3_min_up_no_carry");

    // 4: mode priority and up+down cancel
    step(0,1,0,0, mk(0,11,0,6'b0,1), "t4_mode_ampm");
    step(0,0,1,1, mk(0,11,0,6'b0,1), "t4_ampm_updn");
    step(0,1,0,0, mk(0,11,0,6'b0,0), "t4_mode_run");
    step(0,1,0,0, mk(0,11,0,6'b0,1), "t4_mode_hour");
    step(0,1,1,0, mk(0,11,0,6'b0,1), "t4_mode_plus_up");
    step(0,0,1,1, mk(0,11,0,6'b0,1), "t4_min_updn");
    step(0,0,1,0, mk(0,11,1,6'b0,1), "t4_in_set_min");

    // 5: blink in SET_MIN and SET_AMPM
    step(1,0,0,0, mk(0,11,1,6'b110000,1), "t5_blink1");
    step(1,0,0,0, mk(0,11,1,6'b000000,1), "t5_blink2");
    step(1,0,0,0, mk(0,11,1,6'b110000,1), "t5_blink3");
    step(0,1,0,0, mk(0,11,1,6'b000000,1), "t5_mode_ampm");
    step(1,0,0,0, mk(0,11,1,6'b000001,1), "t5_ampm_blink1");
    step(1,0,0,0, mk(0,11,1,6'b000000,1), "t5_ampm_blink2");
    step(1,0,1,0, mk(1,11,1,6'b000001,1), "t5_tick_and_up");
    step(1,0,1,1, mk(1,11,1,6'b000000,1), "t5_tick_updn");
    step(0,1,0,0, mk(1,11,1,6'b0,0), "t5_mode_run");
    step(1,0,1,0, mk(1,11,1,6'b0,0), "t5_run_tick_up");
    step(1,0,0,1, mk(1,11,2,6'b0,0), "t5_run_tick_dn");

    // 6: edit to 5:37 PM, then reset mid-SET_MIN
    step(0,1,0,0, mk(1,11,2,6'b0,1), "t6_mode_hour");
    step(1,0,0,0, mk(1,11,2,6'b001100,1), "t6_hour_blink");
    for (int i = 1; i <= 6; i++) step(0,0,0,1, mk(1,11-i,2,6'b001100,1), "t6_hr_dn");
    step(0,1,0,0, mk(1,5,2,6'b0,1), "t6_mode_min");
    for (int i = 1; i <= 35; i++) step(0,0,1,0, mk(1,5,2+i,6'b0,1), "t6_min_up");
    #2 reset = 1'b1;
    #1;
    exp_q.push_back(mk(0, 12, 0, 6'b0, 0)); tag_q.push_back("t6_async_reset");
    check_out();
    @(negedge clk);
    reset = 1'b0;
    step(1,0,0,0, mk(0,12,0,6'b0,0), "t6_post_tick1");
    step(1,0,0,0, mk(0,12,1,6'b0,0), "t6_post_tick2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
